bcd_updown_counter: RTL and testbench

- Multi-digit BCD up/down counter with built-in tick prescaler.
- Sits directly upstream of the per-digit BCD-to-7-segment decoders: each 4-bit slice of digits_out drives one decoder's 4-bit input.
- Used for stopwatch, timer and event-count displays on the board's seven-segment bank.
- Guarantees every output nibble is always 0..9, so the decoders never see hex values 10..15.

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bcd_digit.sv | 38 +++
 rtl/bcd_updown_counter.sv | 78 +++++++
 tb/tb_bcd_updown_counter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the seven-segment display path.
// Imported by the counter, its digit slices and other display blocks.
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

    // Force any nibble into the legal BCD range 0..9.
    function automatic logic [BCD_W-1:0] bcd_clamp(
        input logic [BCD_W-1:0] nibble
    );
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit slice: clear > load > step, counting up or down.
// Carry/borrow outputs feed the step input of the next digit.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [BCD_W-1:0] load_nib,
    input  logic             step,
    input  logic             up,
    output logic [BCD_W-1:0] q,
    output logic             carry_out,
    output logic             borrow_out
);

    assign carry_out  = (q == BCD_MAX) & step & up;
    assign borrow_out = (q == BCD_MIN) & step & ~up;

    // Digit register with clear/load priority over stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_MIN;
        end else if (clear) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= load_nib;
        end else if (step) begin
            if (up) begin
                q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
            end else begin
                q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with tick prescaler.
// Every output nibble is guaranteed to stay within 0..9.
module bcd_updown_counter
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      up,
    input  logic                      clear,
    input  logic                      load,
    input  logic [BCD_W*N_DIGITS-1:0] load_val,
    output logic [BCD_W*N_DIGITS-1:0] digits_out,
    output logic                      tick,
    output logic                      wrap
);

    // A divider of 1 still needs a one-bit register that simply stays 0.
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]     pres;
    logic              tick_int;
    logic              advance;
    logic [N_DIGITS:0] step;

    assign tick_int = en & (pres == PRE_LAST);
    assign advance  = tick_int & ~clear & ~load;
    assign step[0]  = tick_int;

    // Prescaler: free-runs while enabled, restarts on clear, load or tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres <= '0;
        end else if (clear || load) begin
            pres <= '0;
        end else if (en) begin
            pres <= tick_int ? '0 : pres + PW'(1);
        end
    end

    // Tick and wrap pulses, aligned with the updated digit value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= advance;
            wrap <= advance & step[N_DIGITS];
        end
    end

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        logic [BCD_W-1:0] nib;
        logic             cy;
        logic             bw;

        assign nib = bcd_clamp(load_val[i*BCD_W +: BCD_W]);
        assign step[i+1] = cy | bw;

        bcd_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear),
            .load       (load),
            .load_nib   (nib),
            .step       (step[i]),
            .up         (up),
            .q          (digits_out[i*BCD_W +: BCD_W]),
            .carry_out  (cy),
            .borrow_out (bw)
        );
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Self-checking bench for bcd_updown_counter (TICK_DIV=4 and TICK_DIV=1).
// Reference model keeps the count as a plain integer modulo 10**N.
module tb_bcd_updown_counter;

    localparam int N   = 4;
    localparam int DIV = 4;
    localparam int MOD = 10000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          up = 1'b1;
    logic          clear = 1'b0;
    logic          load = 1'b0;
    logic [4*N-1:0] load_val = '0;
    logic [4*N-1:0] digits_out;
    logic          tick;
    logic          wrap;

    logic          en1 = 1'b0;
    logic          clear1 = 1'b0;
    logic          load1 = 1'b0;
    logic [4*N-1:0] digits1;
    logic          tick1;
    logic          wrap1;

    int total = 0;
    int bad = 0;

    int m_val = 0;
    int m_pre = 0;
    bit m_tick = 0;
    bit m_wrap = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.N_DIGITS(N), .TICK_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .up         (up),
        .clear      (clear),
        .load       (load),
        .load_val   (load_val),
        .digits_out (digits_out),
        .tick       (tick),
        .wrap       (wrap)
    );

    bcd_updown_counter #(.N_DIGITS(N), .TICK_DIV(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en1),
        .up         (1'b1),
        .clear      (clear1),
        .load       (load1),
        .load_val   ('0),
        .digits_out (digits1),
        .tick       (tick1),
        .wrap       (wrap1)
    );

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < N; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int from_load(input logic [4*N-1:0] lv);
        int v;
        int w;
        int d;
        v = 0;
        w = 1;
        for (int i = 0; i < N; i++) begin
            d = int'(lv[i*4 +: 4]);
            if (d > 9) d = 9;
            v = v + d * w;
            w = w * 10;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_digits"}, 32'(digits_out), 32'(to_bcd(m_val)));
        chk({tag, "_tick"}, 32'(tick), 32'(m_tick));
        chk({tag, "_wrap"}, 32'(wrap), 32'(m_wrap));
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
        end else if (clear) begin
            m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
        end else if (load) begin
            m_val = from_load(load_val);
            m_pre = 0; m_tick = 0; m_wrap = 0;
        end else if (en && m_pre == DIV - 1) begin
            m_pre = 0;
            m_tick = 1;
            if (up) begin
                m_wrap = (m_val == MOD - 1);
                m_val = (m_val + 1) % MOD;
            end else begin
                m_wrap = (m_val == 0);
                m_val = (m_val + MOD - 1) % MOD;
            end
        end else begin
            if (en) m_pre++;
            m_tick = 0;
            m_wrap = 0;
        end
    endtask

    task automatic cyc(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
            check_model(tag);
        end
    endtask

    task automatic do_load(input logic [4*N-1:0] v);
        load = 1'b1;
        load_val = v;
        cyc("load", 1);
        load = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_digits", 32'(digits_out), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        cyc("rst_hold", 2);
        rst_n = 1'b1;

        en = 1'b1; up = 1'b1;
        do_load(16'h0375);
        cyc("pre_rst", 6);
        #2 rst_n = 1'b0;
        #1;
        chk("async_digits", 32'(digits_out), 32'h0);
        chk("async_tick", 32'(tick), 32'h0);
        chk("async_wrap", 32'(wrap), 32'h0);
        m_val = 0; m_pre = 0; m_tick = 0; m_wrap = 0;
        cyc("in_rst", 1);
        rst_n = 1'b1;
        cyc("after_rst", 3);
        chk("first_pre", 32'(tick), 32'h0);
        cyc("after_rst", 1);
        chk("first_tick_val", 32'(digits_out), 32'h0001);
        chk("first_tick", 32'(tick), 32'h1);

        do_load(16'h0199);
        cyc("carry", 4);
        chk("carry_val", 32'(digits_out), 32'h0200);
        do_load(16'h9999);
        cyc("wrap_up", 4);
        chk("wrap_up_val", 32'(digits_out), 32'h0000);
        chk("wrap_up_pulse", 32'(wrap), 32'h1);
        cyc("wrap_up", 1);
        chk("wrap_up_one", 32'(wrap), 32'h0);

        up = 1'b0;
        do_load(16'h1000);
        cyc("borrow", 4);
        chk("borrow_val", 32'(digits_out), 32'h0999);
        do_load(16'h0000);
        cyc("wrap_dn", 4);
        chk("wrap_dn_val", 32'(digits_out), 32'h9999);
        chk("wrap_dn_pulse", 32'(wrap), 32'h1);

        up = 1'b1;
        do_load(16'h0500);
        cyc("hold_a", 2);
        en = 1'b0;
        cyc("hold", 10);
        chk("hold_val", 32'(digits_out), 32'h0500);
        en = 1'b1;
        cyc("hold_b", 1);
        chk("hold_early", 32'(tick), 32'h0);
        cyc("hold_b", 1);
        chk("hold_tick", 32'(tick), 32'h1);
        chk("hold_tick_val", 32'(digits_out), 32'h0501);

        clear = 1'b1; load = 1'b1; load_val = 16'h0042;
        cyc("prio", 1);
        clear = 1'b0; load = 1'b0;
        chk("prio_val", 32'(digits_out), 32'h0000);
        do_load(16'hFA37);
        chk("clamp_val", 32'(digits_out), 32'h9937);

        for (int r = 0; r < 400; r++) begin
            en = ($urandom_range(0, 9) < 8);
            up = 1'($urandom);
            clear = ($urandom_range(0, 49) == 0);
            load = ($urandom_range(0, 29) == 0);
            load_val = 16'($urandom);
            if ($urandom_range(0, 3) == 0) load_val = 16'h9999;
            if ($urandom_range(0, 3) == 0) load_val = 16'h0000;
            cyc("rand", 1);
        end
        clear = 1'b0; load = 1'b0;

        clear1 = 1'b1;
        @(posedge clk); #1;
        clear1 = 1'b0;
        en1 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            chk("div1_val", 32'(digits1), 32'(to_bcd(k)));
            chk("div1_tick", 32'(tick1), 32'h1);
            chk("div1_wrap", 32'(wrap1), 32'h0);
        end
        chk("div1_final", 32'(digits1), 32'h0012);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
